fetch_stage: RTL and testbench

Instruction-fetch front end for the 16-bit mini-MIPS datapath. It owns the PC, drives the instruction-memory address, and registers each fetched word into an IF/ID pipeline register with a valid flag for the decode/register-file/ALU stage. It also handles decode stalls, branch/jump redirects with flush, and a HALT opcode.

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end for the 16-bit mini-MIPS datapath.
// Owns the PC, drives the instruction-memory address and registers each
// accepted word into the IF/ID register. Also handles decode stalls,
// redirect with flush, and a HALT opcode that parks fetch until redirect.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_WORDS = 256,
    parameter logic [3:0]  HALT_OP    = 4'b1111
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_next,
    output logic        halted,
    output logic [15:0] fetch_count
);

    // IMEM_WORDS is a power of two, so masking gives the modulo wrap and
    // keeps the PC bits above the memory index at zero.
    localparam logic [15:0] PC_MASK = 16'(IMEM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc_d, pc_inc;
    logic        ifid_valid_d, halted_d;
    logic [15:0] ifid_instr_d, ifid_pc_d, ifid_pc_next_d, fetch_count_d;

    assign imem_addr = pc;
    assign pc_inc    = (pc + 16'd1) & PC_MASK;

    // State and pipeline registers; reset clears everything asynchronously.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= RESET_PC & PC_MASK;
            ifid_valid   <= 1'b0;
            ifid_instr   <= 16'h0000;
            ifid_pc      <= 16'h0000;
            ifid_pc_next <= 16'h0000;
            halted       <= 1'b0;
            fetch_count  <= 16'h0000;
        end else begin
            state        <= state_next;
            pc           <= pc_d;
            ifid_valid   <= ifid_valid_d;
            ifid_instr   <= ifid_instr_d;
            ifid_pc      <= ifid_pc_d;
            ifid_pc_next <= ifid_pc_next_d;
            halted       <= halted_d;
            fetch_count  <= fetch_count_d;
        end
    end

    // Next-state logic: redirect beats stall; stall freezes everything.
    // NOTE: every output of this block gets a hold default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        pc_d           = pc;
        ifid_valid_d   = ifid_valid;
        ifid_instr_d   = ifid_instr;
        ifid_pc_d      = ifid_pc;
        ifid_pc_next_d = ifid_pc_next;
        halted_d       = halted;
        fetch_count_d  = fetch_count;

        if (state == IDLE) begin
            // One dead cycle after reset; redirect is ignored here.
            state_next = FETCH;
        end else if (redirect) begin
            // Flush: the word on imem_data this cycle is dropped.
            pc_d         = redirect_pc & PC_MASK;
            ifid_valid_d = 1'b0;
            halted_d     = 1'b0;
            state_next   = FETCH;
        end else if (!stall) begin
            if (state == FETCH) begin
                ifid_instr_d   = imem_data;
                ifid_pc_d      = pc;
                ifid_pc_next_d = pc_inc;
                ifid_valid_d   = 1'b1;
                if (fetch_count != 16'hFFFF) begin
                    fetch_count_d = fetch_count + 16'd1;
                end
                if (imem_data[15:12] == HALT_OP) begin
                    // PC stays on the HALT word.
                    halted_d   = 1'b1;
                    state_next = HALT;
                end else begin
                    pc_d = pc_inc;
                end
            end else begin
                // HALT: the HALT word has been seen once; retire it.
                ifid_valid_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model predicts each
// edge, accepted fetches are queued as expected IF/ID contents and popped
// when the DUT registers them.
module tb_fetch_stage;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_next;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_next;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];
    exp_t        sb [$];

    int errors = 0;
    int checks = 0;

    // Bench model state (0 idle, 1 fetch, 2 halt)
    int          m_state;
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_count;

    fetch_stage dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pc_next (ifid_pc_next),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    assign imem_data = mem[imem_addr[7:0]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] actual,
                         input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_pc     = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_count  = 16'h0000;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc"},      pc, 16'h0000);
        check({tag, ".valid"},   {15'd0, ifid_valid}, 16'h0000);
        check({tag, ".instr"},   ifid_instr, 16'h0000);
        check({tag, ".ifid_pc"}, ifid_pc, 16'h0000);
        check({tag, ".pcnext"},  ifid_pc_next, 16'h0000);
        check({tag, ".halted"},  {15'd0, halted}, 16'h0000);
        check({tag, ".count"},   fetch_count, 16'h0000);
    endtask

    // One clock: drive inputs, predict, advance, then compare 1 unit later.
    task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc);
        logic accept;
        exp_t e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        accept = (m_state == 1) && !rd && !st;
        if (accept) begin
            e.instr   = mem[m_pc[7:0]];
            e.pc      = m_pc;
            e.pc_next = (m_pc + 16'd1) & 16'h00FF;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (m_state == 0) begin
            m_state = 1;
        end else if (rd) begin
            m_pc     = rpc & 16'h00FF;
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_state  = 1;
        end else if (!st && m_state == 1) begin
            m_valid = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (mem[m_pc[7:0]][15:12] == 4'hF) begin
                m_state  = 2;
                m_halted = 1'b1;
            end else begin
                m_pc = (m_pc + 16'd1) & 16'h00FF;
            end
        end else if (!st && m_state == 2) begin
            m_valid = 1'b0;
        end
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("valid", {15'd0, ifid_valid}, {15'd0, m_valid});
        check("halted", {15'd0, halted}, {15'd0, m_halted});
        check("count", fetch_count, m_count);
        if (accept) begin
            if (sb.size() == 0) begin
                check("sb_empty", 16'h0001, 16'h0000);
            end else begin
                e = sb.pop_front();
                check("ifid_instr", ifid_instr, e.instr);
                check("ifid_pc", ifid_pc, e.pc);
                check("ifid_pc_next", ifid_pc_next, e.pc_next);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
        mem[0] = 16'h700F;
        mem[1] = 16'h7027;
        mem[2] = 16'h2130;
        mem[5] = 16'hF000;

        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        reset_n     = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // IDLE edge, then fetch addresses 0 and 1
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        check("first_instr", ifid_instr, 16'h700F);
        cycle(1'b0, 1'b0, 16'h0);
        // Stall three cycles holding ifid_pc=1
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0);
        check("stall_instr", ifid_instr, 16'h7027);
        check("stall_pc", pc, 16'h0002);
        cycle(1'b0, 1'b0, 16'h0);
        check("count3", fetch_count, 16'h0003);
        check("instr2", ifid_instr, 16'h2130);

        // Redirect overrides stall, then fetch at 0x40
        cycle(1'b1, 1'b1, 16'h0040);
        cycle(1'b0, 1'b0, 16'h0);
        check("redir_ifid_pc", ifid_pc, 16'h0040);

        // Run into HALT at address 5
        cycle(1'b0, 1'b1, 16'h0003);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0);
        check("halt_instr", ifid_instr, 16'hF000);
        cycle(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0);
        check("halt_pc", pc, 16'h0005);

        // Redirect out of HALT
        cycle(1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0);

        // Wrap-around at 0xFF, plus masking of an out-of-range target
        cycle(1'b0, 1'b1, 16'h00FF);
        cycle(1'b0, 1'b0, 16'h0);
        check("wrap_pc_next", ifid_pc_next, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0123);
        cycle(1'b0, 1'b0, 16'h0);

        // Redirect on the same edge as a HALT fetch: redirect wins
        cycle(1'b0, 1'b1, 16'h0005);
        cycle(1'b0, 1'b1, 16'h0010);
        cycle(1'b0, 1'b0, 16'h0);

        // Asynchronous reset mid-stream, between edges
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        // Redirect in IDLE is ignored; fetch restarts at RESET_PC
        cycle(1'b0, 1'b1, 16'h0077);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        check("restart_instr", ifid_instr, 16'h7027);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
